// File: rtl/calc_pkg.sv
// Shared keycodes, operator and FSM state encodings for the keypad calculator core.
package calc_pkg;

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_SUB  = 5'h11;
  localparam logic [4:0] KEY_MUL  = 5'h12;
  localparam logic [4:0] KEY_EQU  = 5'h13;
  localparam logic [4:0] KEY_CLR  = 5'h14;
  localparam logic [4:0] KEY_ACLR = 5'h15;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  typedef enum logic [2:0] {
    S_START,
    S_ENTRY,
    S_OPWAIT,
    S_RESULT,
    S_BUSY
  } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// W-bit sequential shift-add multiplier: one partial product per cycle, W cycles.
// done is asserted during the last iteration with p/ovf showing the final product.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run;
  logic [2*W-1:0] acc_nx;

  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
    done   = run && (cnt == CW'(W - 1));
    p      = acc_nx[W-1:0];
    ovf    = |acc_nx[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Keypad-driven calculator core: hex entry, chained add/sub, overflow flag.
// Multiply (iterative, busy/key_drop reporting) is present only when CALC_MUL_EN is defined.
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned KEYW   = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [KEYW-1:0]       keycode,
  input  logic                  new_key,
  output logic [4*DIGITS-1:0]   x,
  output logic                  ovf,
  output logic                  busy,
  output logic                  key_drop
);

  localparam int unsigned W = 4 * DIGITS;

  state_t       state, state_n;
  op_t          op_r, op_n;
  logic [W-1:0] x_r, x_n, y_r, y_n;
  logic         ovf_r, ovf_n;
  logic         pend_r, pend_n;
  logic         drop_r, drop_n;

  logic         is_digit, is_opkey;
  op_t          k_op;
  logic [W:0]   alu;

  logic         mul_done;
  logic [W-1:0] mul_p;
  logic         mul_ovf;

`ifdef CALC_MUL_EN
  logic mul_start;
  assign mul_start = (state != S_BUSY) && (state_n == S_BUSY);

  calc_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rstn  (rstn),
    .start (mul_start),
    .a     (y_r),
    .b     (x_r),
    .done  (mul_done),
    .p     (mul_p),
    .ovf   (mul_ovf)
  );
`else
  assign mul_done = 1'b0;
  assign mul_p    = '0;
  assign mul_ovf  = 1'b0;
`endif

  always_comb begin
    is_digit = (keycode < KEYW'(16));
    is_opkey = 1'b1;
    k_op     = OP_NONE;
    if (keycode == KEYW'(KEY_ADD))      k_op = OP_ADD;
    else if (keycode == KEYW'(KEY_SUB)) k_op = OP_SUB;
`ifdef CALC_MUL_EN
    else if (keycode == KEYW'(KEY_MUL)) k_op = OP_MUL;
`endif
    else                                is_opkey = 1'b0;

    // bit W carries the ADD carry-out or the SUB borrow (y < x)
    case (op_r)
      OP_ADD:  alu = {1'b0, y_r} + {1'b0, x_r};
      OP_SUB:  alu = {1'b0, y_r} - {1'b0, x_r};
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    x_n     = x_r;
    y_n     = y_r;
    op_n    = op_r;
    ovf_n   = ovf_r;
    pend_n  = pend_r;
    drop_n  = 1'b0;

    if (state == S_BUSY) begin
      drop_n = new_key;
      if (mul_done) begin
        x_n   = mul_p;
        ovf_n = mul_ovf;
        if (pend_r) begin
          y_n     = mul_p;
          state_n = S_OPWAIT;
        end else begin
          state_n = S_RESULT;
        end
      end
    end else if (new_key) begin
      if (is_digit) begin
        if (state == S_ENTRY) begin
          x_n = {x_r[W-5:0], keycode[3:0]};
        end else begin
          x_n = W'(keycode[3:0]);
          if (state == S_RESULT) op_n = OP_NONE;
        end
        state_n = S_ENTRY;
      end else if (is_opkey) begin
        if (state == S_OPWAIT) begin
          op_n = k_op;
        end else if (state == S_ENTRY && op_r != OP_NONE) begin
          // chaining: pending op completes, the new op waits for the next operand
          op_n = k_op;
          if (op_r == OP_MUL) begin
            pend_n  = 1'b1;
            state_n = S_BUSY;
          end else begin
            x_n     = alu[W-1:0];
            y_n     = alu[W-1:0];
            ovf_n   = alu[W];
            state_n = S_OPWAIT;
          end
        end else begin
          y_n     = x_r;
          op_n    = k_op;
          state_n = S_OPWAIT;
        end
      end else if (keycode == KEYW'(KEY_EQU)) begin
        if (state == S_ENTRY && op_r != OP_NONE) begin
          op_n = OP_NONE;
          if (op_r == OP_MUL) begin
            pend_n  = 1'b0;
            state_n = S_BUSY;
          end else begin
            x_n     = alu[W-1:0];
            ovf_n   = alu[W];
            state_n = S_RESULT;
          end
        end
      end else if (keycode == KEYW'(KEY_CLR)) begin
        x_n     = '0;
        ovf_n   = 1'b0;
        state_n = (op_r != OP_NONE) ? S_OPWAIT : S_START;
      end else if (keycode == KEYW'(KEY_ACLR)) begin
        x_n     = '0;
        y_n     = '0;
        op_n    = OP_NONE;
        ovf_n   = 1'b0;
        pend_n  = 1'b0;
        state_n = S_START;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_START;
      op_r   <= OP_NONE;
      x_r    <= '0;
      y_r    <= '0;
      ovf_r  <= 1'b0;
      pend_r <= 1'b0;
      drop_r <= 1'b0;
    end else begin
      state  <= state_n;
      op_r   <= op_n;
      x_r    <= x_n;
      y_r    <= y_n;
      ovf_r  <= ovf_n;
      pend_r <= pend_n;
      drop_r <= drop_n;
    end
  end

  assign x        = x_r;
  assign ovf      = ovf_r;
  assign busy     = (state == S_BUSY);
  assign key_drop = drop_r;

endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine (DIGITS=4); MUL tests run when CALC_MUL_EN is defined.
module tb_calc_engine;

  logic        clk;
  logic        rstn;
  logic [4:0]  keycode;
  logic        new_key;
  logic [15:0] x;
  logic        ovf;
  logic        busy;
  logic        key_drop;

  int total = 0;
  int bad   = 0;

  calc_engine #(.DIGITS(4), .KEYW(5)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .keycode  (keycode),
    .new_key  (new_key),
    .x        (x),
    .ovf      (ovf),
    .busy     (busy),
    .key_drop (key_drop)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    keycode = k;
    new_key = 1'b1;
    @(negedge clk);
    new_key = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (x !== 16'h0000) begin bad++; $display("FAIL reset_x got=%h want=0000", x); end
    total++; if (ovf !== 1'b0 || busy !== 1'b0 || key_drop !== 1'b0) begin
      bad++; $display("FAIL reset_flags got ovf=%b busy=%b drop=%b want 0 0 0", ovf, busy, key_drop);
    end
    // F,F,F,F,ADD,2,EQU -> 0xFFFF+2 = 0x0001 with carry
    press(5'h0F); press(5'h0F); press(5'h0F); press(5'h0F);
    press(5'h10); press(5'h02); press(5'h13);
    total++; if (x !== 16'h0001 || ovf !== 1'b1) begin
      bad++; $display("FAIL pre_reset got x=%h ovf=%b want x=0001 ovf=1", x, ovf);
    end
    #3 rstn = 1'b0;
    #1;
    total++; if (x !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL async_reset got x=%h ovf=%b busy=%b want 0000 0 0", x, ovf, busy);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_entry;
    logic [15:0] exp_x [5];
    exp_x[0] = 16'h0001; exp_x[1] = 16'h0012; exp_x[2] = 16'h0123;
    exp_x[3] = 16'h1234; exp_x[4] = 16'h2345;
    press(5'h15);
    for (int i = 0; i < 5; i++) begin
      press(5'(i + 1));
      total++; if (x !== exp_x[i] || ovf !== 1'b0) begin
        bad++; $display("FAIL entry_%0d got x=%h ovf=%b want x=%h ovf=0", i, x, ovf, exp_x[i]);
      end
    end
  endtask

  task automatic test_add_ovf;
    press(5'h15);
    press(5'h0F); press(5'h0F); press(5'h10);
    total++; if (x !== 16'h00FF) begin bad++; $display("FAIL add_operand got=%h want=00FF", x); end
    press(5'h0F); press(5'h0F); press(5'h00); press(5'h01); press(5'h13);
    total++; if (x !== 16'h0000 || ovf !== 1'b1) begin
      bad++; $display("FAIL add_carry got x=%h ovf=%b want x=0000 ovf=1", x, ovf);
    end
    press(5'h14);
    total++; if (x !== 16'h0000 || ovf !== 1'b0) begin
      bad++; $display("FAIL clr got x=%h ovf=%b want x=0000 ovf=0", x, ovf);
    end
  endtask

  task automatic test_chain;
    press(5'h15);
    press(5'h05); press(5'h11); press(5'h07); press(5'h10);
    total++; if (x !== 16'hFFFE || ovf !== 1'b1) begin
      bad++; $display("FAIL chain_sub got x=%h ovf=%b want x=FFFE ovf=1", x, ovf);
    end
    // 0xFFFE + 3 = 0x10001: carry out of the top bit
    press(5'h03); press(5'h13);
    total++; if (x !== 16'h0001 || ovf !== 1'b1) begin
      bad++; $display("FAIL chain_add got x=%h ovf=%b want x=0001 ovf=1", x, ovf);
    end
    press(5'h13);
    total++; if (x !== 16'h0001 || ovf !== 1'b1) begin
      bad++; $display("FAIL equ_repeat got x=%h ovf=%b want x=0001 ovf=1", x, ovf);
    end
  endtask

  task automatic test_back_to_back;
    press(5'h15);
    press(5'h09); press(5'h10); press(5'h11); press(5'h04); press(5'h13);
    total++; if (x !== 16'h0005 || ovf !== 1'b0) begin
      bad++; $display("FAIL op_replace got x=%h ovf=%b want x=0005 ovf=0", x, ovf);
    end
    press(5'h01); press(5'h10); press(5'h02); press(5'h10);
    total++; if (x !== 16'h0003) begin bad++; $display("FAIL chain3_mid got=%h want=0003", x); end
    press(5'h03); press(5'h13);
    total++; if (x !== 16'h0006) begin bad++; $display("FAIL chain3_end got=%h want=0006", x); end
    press(5'h15);
    press(5'h06); press(5'h10); press(5'h09); press(5'h14);
    total++; if (x !== 16'h0000) begin bad++; $display("FAIL clr_keep_op got=%h want=0000", x); end
    press(5'h02); press(5'h13);
    total++; if (x !== 16'h0008) begin bad++; $display("FAIL clr_then_equ got=%h want=0008", x); end
    press(5'h16);
    total++; if (x !== 16'h0008) begin bad++; $display("FAIL unmapped_key got=%h want=0008", x); end
  endtask

`ifdef CALC_MUL_EN
  task automatic test_mul;
    int cnt;
    press(5'h15);
    press(5'h01); press(5'h00); press(5'h00); press(5'h12);
    press(5'h02); press(5'h00); press(5'h00); press(5'h13);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 4) begin
        total++; if (key_drop !== 1'b1 || x !== 16'h0200) begin
          bad++; $display("FAIL drop_pulse got drop=%b x=%h want drop=1 x=0200", key_drop, x);
        end
      end
      if (cnt == 5) begin
        total++; if (key_drop !== 1'b0) begin bad++; $display("FAIL drop_width got=%b want=0", key_drop); end
      end
      if (cnt == 3) begin keycode = 5'h07; new_key = 1'b1; end
      else new_key = 1'b0;
      @(negedge clk);
    end
    new_key = 1'b0;
    total++; if (cnt !== 16) begin bad++; $display("FAIL busy_cycles got=%0d want=16", cnt); end
    total++; if (x !== 16'h0000 || ovf !== 1'b1) begin
      bad++; $display("FAIL mul_result got x=%h ovf=%b want x=0000 ovf=1", x, ovf);
    end
    press(5'h02); press(5'h12); press(5'h03); press(5'h13);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul2_busy got=%b want=1", busy); end
    repeat (3) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    total++; if (x !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0 || key_drop !== 1'b0) begin
      bad++; $display("FAIL mul_abort got x=%h ovf=%b busy=%b drop=%b want 0000 0 0 0", x, ovf, busy, key_drop);
    end
    @(negedge clk); rstn = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (x !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL post_abort got x=%h busy=%b want 0000 0", x, busy);
    end
  endtask
`else
  task automatic test_no_mul;
    logic seen_busy;
    seen_busy = 1'b0;
    press(5'h15);
    press(5'h03); seen_busy |= busy | key_drop;
    press(5'h12); seen_busy |= busy | key_drop;
    press(5'h04); seen_busy |= busy | key_drop;
    total++; if (x !== 16'h0034) begin bad++; $display("FAIL mul_ignored got=%h want=0034", x); end
    total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL busy_seen got=%b want=0", seen_busy); end
  endtask
`endif

  initial begin
    rstn    = 1'b0;
    keycode = '0;
    new_key = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_entry();
    test_add_ovf();
    test_chain();
    test_back_to_back();
`ifdef CALC_MUL_EN
    test_mul();
`else
    test_no_mul();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
